// File: rtl/t05_flv_pkg.sv
// Shared types and constants for the FLV tree-build controller.
// Contents: controller state enum, SRAM layout constants, node-id helpers.
package t05_flv_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LAUNCH,
        WAIT_FLV,
        WIPE1,
        WIPE2,
        WRSUM,
        EMIT,
        DONE,
        ERR
    } flv_ctrl_state_t;

    localparam logic [8:0] SUM_BASE     = 9'd256;
    localparam logic [7:0] MAX_SUMS     = 8'd128;
    localparam logic [3:0] STATE_FLV    = 4'd2;
    localparam logic [8:0] NODE_INVALID = 9'b110000000;
    localparam int         TIMEOUT_CYC  = 1024;

    // Leaves live at their character code, sum nodes above SUM_BASE.
    function automatic logic [8:0] node2addr(input logic [8:0] id);
        node2addr = id[8] ? (SUM_BASE + {1'b0, id[7:0]}) : {1'b0, id[7:0]};
    endfunction

endpackage

// File: rtl/t05_flv_controller_sram_seq.sv
// Request/ack holder for the shared SRAM port.
// load_i captures a new request; address/data then stay fixed until ack_i.
// en_i low freezes everything; clr_i drops an outstanding request.
// Ports: clk_i, rst_n_i, en_i, load_i, clr_i, addr_i, data_i, ack_i,
//        req_o, addr_o, data_o.
module t05_flv_sram_seq #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 64
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              en_i,
    input  logic              load_i,
    input  logic              clr_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              ack_i,
    output logic              req_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] data_o
);

    logic              req_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            req_q  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else if (en_i) begin
            if (clr_i) begin
                req_q <= 1'b0;
            end else if (load_i) begin
                // A load on the ack cycle chains straight into the next write.
                req_q  <= 1'b1;
                addr_q <= addr_i;
                data_q <= data_i;
            end else if (ack_i) begin
                req_q <= 1'b0;
            end
        end
    end

    assign req_o  = req_q;
    assign addr_o = addr_q;
    assign data_o = data_q;

endmodule

// File: rtl/t05_flv_controller.sv
// Huffman tree-build sequencer around the find-least-value datapath.
// Launches FLV passes, wipes the two consumed entries, writes the merged sum
// node and emits one tree-node record per pass until a single root remains.
// Ports: clk_i/nRst_i, en_state_i (advance only in STATE_FLV), start_i,
//        leaf_cnt_i; FLV handshake flv_*; SRAM port sram_*; node record
//        node_*; status sum_cnt_o, busy_o, fin_o, err_o.
// Optional: define T05_FLV_CTRL_TIMEOUT_EN for a watchdog that forces ERR
//           when a wait state lasts TIMEOUT_CYC cycles.
//
// state    | meaning
// IDLE     | waiting for start
// LAUNCH   | pulse flv_start
// WAIT_FLV | waiting for flv_done, latch result
// WIPE1    | zero SRAM entry of least1
// WIPE2    | zero SRAM entry of least2
// WRSUM    | write merged sum node
// EMIT     | present node record until accepted
// DONE     | tree complete (sticky)
// ERR      | error (sticky)
module t05_flv_controller
    import t05_flv_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int NODE_W = 9
) (
    input  logic              clk_i,
    input  logic              nRst_i,
    input  logic [3:0]        en_state_i,
    input  logic              start_i,
    input  logic [8:0]        leaf_cnt_i,
    output logic              flv_start_o,
    input  logic              flv_done_i,
    input  logic [NODE_W-1:0] flv_least1_i,
    input  logic [NODE_W-1:0] flv_least2_i,
    input  logic [DATA_W-1:0] flv_sum_i,
    output logic              sram_req_o,
    output logic              sram_wr_o,
    output logic [8:0]        sram_addr_o,
    output logic [DATA_W-1:0] sram_wdata_o,
    input  logic              sram_ack_i,
    output logic              node_valid_o,
    input  logic              node_ready_i,
    output logic [6:0]        node_id_o,
    output logic [NODE_W-1:0] node_l_o,
    output logic [NODE_W-1:0] node_r_o,
    output logic [7:0]        sum_cnt_o,
    output logic              busy_o,
    output logic              fin_o,
    output logic              err_o
);

    flv_ctrl_state_t   state_q, state_d;
    logic [8:0]        remaining_q, remaining_d;
    logic [7:0]        sum_cnt_q, sum_cnt_d;
    logic [NODE_W-1:0] least1_q, least1_d, least2_q, least2_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              en;
    logic              seq_load, seq_clr, seq_req;
    logic [8:0]        seq_addr;
    logic [DATA_W-1:0] seq_data;

    assign en = (en_state_i == STATE_FLV);

`ifdef T05_FLV_CTRL_TIMEOUT_EN
    // Down-counter reloaded on every state change; trips so that ERR lands
    // exactly TIMEOUT_CYC cycles after the state before the wait.
    localparam logic [9:0] WDOG_LOAD = 10'(TIMEOUT_CYC - 1);
    logic [9:0] wdog_q;
    logic       wdog_watch;

    assign wdog_watch = (state_q inside {WAIT_FLV, WIPE1, WIPE2, WRSUM});

    always_ff @(posedge clk_i or negedge nRst_i) begin
        if (!nRst_i) begin
            wdog_q <= '0;
        end else if (state_d != state_q) begin
            wdog_q <= WDOG_LOAD;
        end else if (en && wdog_watch && (wdog_q != 10'd0)) begin
            wdog_q <= wdog_q - 10'd1;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        sum_cnt_d   = sum_cnt_q;
        least1_d    = least1_q;
        least2_d    = least2_q;
        sum_d       = sum_q;
        if (en) begin
            case (state_q)
                IDLE: if (start_i) begin
                    remaining_d = leaf_cnt_i;
                    if (leaf_cnt_i == 9'd0)      state_d = ERR;
                    else if (leaf_cnt_i == 9'd1) state_d = DONE;
                    else                         state_d = LAUNCH;
                end
                LAUNCH: state_d = WAIT_FLV;
                WAIT_FLV: if (flv_done_i) begin
                    least1_d = flv_least1_i;
                    least2_d = flv_least2_i;
                    sum_d    = flv_sum_i;
                    if ((flv_least1_i == flv_least2_i) ||
                        (flv_least1_i[8:7] == NODE_INVALID[8:7]) ||
                        (flv_least2_i[8:7] == NODE_INVALID[8:7]))
                        state_d = ERR;
                    else
                        state_d = WIPE1;
                end
                WIPE1: if (sram_ack_i) state_d = WIPE2;
                WIPE2: if (sram_ack_i) state_d = (sum_cnt_q == MAX_SUMS) ? ERR : WRSUM;
                WRSUM: if (sram_ack_i) state_d = EMIT;
                EMIT: if (node_ready_i) begin
                    sum_cnt_d   = sum_cnt_q + 8'd1;
                    remaining_d = remaining_q - 9'd1;
                    state_d     = (remaining_q == 9'd2) ? DONE : LAUNCH;
                end
                default: ;
            endcase
`ifdef T05_FLV_CTRL_TIMEOUT_EN
            if (wdog_watch && (wdog_q == 10'd1)) state_d = ERR;
`endif
        end
    end

    always_ff @(posedge clk_i or negedge nRst_i) begin
        if (!nRst_i) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            sum_cnt_q   <= '0;
            least1_q    <= '0;
            least2_q    <= '0;
            sum_q       <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            sum_cnt_q   <= sum_cnt_d;
            least1_q    <= least1_d;
            least2_q    <= least2_d;
            sum_q       <= sum_d;
        end
    end

    // The write request is loaded on entry to each write state, so WIPE1 uses
    // the FLV result directly (it is being latched on the same edge).
    always_comb begin
        seq_load = (state_d != state_q) && (state_d inside {WIPE1, WIPE2, WRSUM});
        seq_clr  = (state_d == ERR);
        seq_data = '0;
        case (state_d)
            WIPE1:   seq_addr = node2addr(flv_least1_i);
            WIPE2:   seq_addr = node2addr(least2_q);
            default: seq_addr = SUM_BASE + {1'b0, sum_cnt_q};
        endcase
        if (state_d == WRSUM) seq_data = sum_q;
    end

    t05_flv_sram_seq #(
        .ADDR_W(9),
        .DATA_W(DATA_W)
    ) u_sram_seq (
        .clk_i  (clk_i),
        .rst_n_i(nRst_i),
        .en_i   (en),
        .load_i (seq_load),
        .clr_i  (seq_clr),
        .addr_i (seq_addr),
        .data_i (seq_data),
        .ack_i  (sram_ack_i),
        .req_o  (seq_req),
        .addr_o (sram_addr_o),
        .data_o (sram_wdata_o)
    );

    assign sram_req_o   = seq_req;
    assign sram_wr_o    = seq_req;
    assign flv_start_o  = en && (state_q == LAUNCH);
    assign node_valid_o = (state_q == EMIT);
    assign node_id_o    = sum_cnt_q[6:0];
    assign node_l_o     = least1_q;
    assign node_r_o     = least2_q;
    assign sum_cnt_o    = sum_cnt_q;
    assign busy_o       = !(state_q inside {IDLE, DONE, ERR});
    assign fin_o        = (state_q == DONE);
    assign err_o        = (state_q == ERR);

endmodule

// File: tb/tb_t05_flv_controller.sv
// Directed bench for t05_flv_controller: FLV, SRAM and node-consumer
// responders run on the falling edge; the main sequence checks hand-computed
// write streams, node records and status levels.
module tb_t05_flv_controller;
    import t05_flv_pkg::*;

    logic        clk = 1'b0;
    logic        nRst = 1'b0;
    logic [3:0]  en_state = 4'd2;
    logic        start = 1'b0;
    logic [8:0]  leaf_cnt = '0;
    logic        flv_start;
    logic        flv_done = 1'b0;
    logic [8:0]  flv_least1 = '0, flv_least2 = '0;
    logic [63:0] flv_sum = '0;
    logic        sram_req, sram_wr, sram_ack = 1'b0;
    logic [8:0]  sram_addr;
    logic [63:0] sram_wdata;
    logic        node_valid, node_ready = 1'b0;
    logic [6:0]  node_id;
    logic [8:0]  node_l, node_r;
    logic [7:0]  sum_cnt;
    logic        busy, fin, err;

    always #5 clk = ~clk;

    t05_flv_controller dut (
        .clk_i(clk), .nRst_i(nRst), .en_state_i(en_state), .start_i(start),
        .leaf_cnt_i(leaf_cnt), .flv_start_o(flv_start), .flv_done_i(flv_done),
        .flv_least1_i(flv_least1), .flv_least2_i(flv_least2), .flv_sum_i(flv_sum),
        .sram_req_o(sram_req), .sram_wr_o(sram_wr), .sram_addr_o(sram_addr),
        .sram_wdata_o(sram_wdata), .sram_ack_i(sram_ack), .node_valid_o(node_valid),
        .node_ready_i(node_ready), .node_id_o(node_id), .node_l_o(node_l),
        .node_r_o(node_r), .sum_cnt_o(sum_cnt), .busy_o(busy), .fin_o(fin), .err_o(err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // responder state
    logic [8:0]  v_l1 [4];
    logic [8:0]  v_l2 [4];
    logic [63:0] v_sum [4];
    int flv_idx, flv_pend, flv_starts;
    bit flv_mute;
    int ack_dly [8];
    int wr_n, ack_wait;
    int rdy_dly [4];
    int nd_n, rd_wait;
    logic [8:0]  wr_addr_q [$];
    logic [63:0] wr_data_q [$];
    logic [8:0]  nd_l_q [$], nd_r_q [$];
    logic [6:0]  nd_id_q [$];

    task automatic clear_model();
        flv_idx = 0; flv_pend = 0; flv_starts = 0; flv_mute = 1'b0;
        wr_n = 0; ack_wait = 0; nd_n = 0; rd_wait = 0;
        for (int i = 0; i < 8; i++) ack_dly[i] = 0;
        for (int i = 0; i < 4; i++) rdy_dly[i] = 0;
        wr_addr_q.delete(); wr_data_q.delete();
        nd_l_q.delete(); nd_r_q.delete(); nd_id_q.delete();
    endtask

    // FLV datapath: answers two cycles after each launch
    initial forever begin
        @(negedge clk);
        flv_done = 1'b0;
        if (nRst && en_state == 4'd2) begin
            if (flv_start) begin
                flv_starts++;
                if (!flv_mute) flv_pend = 2;
            end else if (flv_pend > 0) begin
                flv_pend--;
                if (flv_pend == 0) begin
                    flv_done = 1'b1;
                    flv_least1 = v_l1[flv_idx % 4];
                    flv_least2 = v_l2[flv_idx % 4];
                    flv_sum = v_sum[flv_idx % 4];
                    flv_idx++;
                end
            end
        end
    end

    // SRAM: acks each request after ack_dly[n] waiting cycles, logs writes
    initial forever begin
        @(negedge clk);
        sram_ack = 1'b0;
        if (nRst && en_state == 4'd2 && sram_req) begin
            if (ack_wait < ack_dly[wr_n % 8]) ack_wait++;
            else begin
                sram_ack = 1'b1;
                wr_addr_q.push_back(sram_addr);
                wr_data_q.push_back(sram_wdata);
                wr_n++;
                ack_wait = 0;
            end
        end
    end

    // node consumer: accepts after rdy_dly[n] stalled cycles
    initial forever begin
        @(negedge clk);
        node_ready = 1'b0;
        if (nRst && en_state == 4'd2 && node_valid) begin
            if (rd_wait < rdy_dly[nd_n % 4]) rd_wait++;
            else begin
                node_ready = 1'b1;
                nd_id_q.push_back(node_id);
                nd_l_q.push_back(node_l);
                nd_r_q.push_back(node_r);
                nd_n++;
                rd_wait = 0;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        nRst = 1'b0;
        start = 1'b0;
        en_state = 4'd2;
        clear_model();
        @(negedge clk);
        @(negedge clk);
        nRst = 1'b1;
    endtask

    task automatic pulse_start(input logic [8:0] n);
        @(negedge clk);
        leaf_cnt = n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int budget);
        for (int i = 0; i < budget && !fin && !err; i++) @(negedge clk);
        check({tag, "_ended"}, fin | err, 1);
    endtask

    task automatic wait_req_at(input string tag, input logic [8:0] a, input int budget);
        for (int i = 0; i < budget && !(sram_req && sram_addr == a); i++) @(negedge clk);
        check({tag, "_req"}, {sram_req, sram_addr}, {1'b1, a});
    endtask

    task automatic check_writes(input string tag, input logic [8:0] ea [6],
                                input logic [63:0] ed [6], input int n);
        check({tag, "_nwr"}, wr_addr_q.size(), n);
        for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
            check($sformatf("%s_wa%0d", tag, i), wr_addr_q[i], ea[i]);
            check($sformatf("%s_wd%0d", tag, i), wr_data_q[i], ed[i]);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_req"}, sram_req, 0);
        check({tag, "_wr"}, sram_wr, 0);
        check({tag, "_addr"}, sram_addr, 0);
        check({tag, "_wdata"}, sram_wdata, 0);
        check({tag, "_fstart"}, flv_start, 0);
        check({tag, "_nvalid"}, node_valid, 0);
        check({tag, "_nid"}, {node_id, node_l, node_r}, 0);
        check({tag, "_sumcnt"}, sum_cnt, 0);
        check({tag, "_status"}, {busy, fin, err}, 0);
    endtask

    logic [8:0]  ea [6];
    logic [63:0] ed [6];

    initial begin
        clear_model();
        for (int i = 0; i < 4; i++) begin
            v_l1[i] = '0; v_l2[i] = '0; v_sum[i] = '0;
        end
        #1;
        check_outputs_zero("rst");
        do_reset();

        // three leaves: two passes, root is sum node 1
        v_l1[0] = 9'h041; v_l2[0] = 9'h042; v_sum[0] = 64'd5;
        v_l1[1] = 9'h100; v_l2[1] = 9'h043; v_sum[1] = 64'd9;
        pulse_start(9'd3);
        check("t1_busy", busy, 1);
        wait_end("t1", 200);
        ea = '{9'h041, 9'h042, 9'd256, 9'd256, 9'h043, 9'd257};
        ed = '{64'd0, 64'd0, 64'd5, 64'd0, 64'd0, 64'd9};
        check_writes("t1", ea, ed, 6);
        check("t1_nnodes", nd_id_q.size(), 2);
        if (nd_id_q.size() == 2) begin
            check("t1_n0", {nd_id_q[0], nd_l_q[0], nd_r_q[0]}, {7'd0, 9'h041, 9'h042});
            check("t1_n1", {nd_id_q[1], nd_l_q[1], nd_r_q[1]}, {7'd1, 9'h100, 9'h043});
        end
        check("t1_fin_err_busy", {fin, err, busy}, 3'b100);
        check("t1_sumcnt", sum_cnt, 2);
        check("t1_starts", flv_starts, 2);

        // single leaf: done one cycle after start, nothing issued
        do_reset();
        pulse_start(9'd1);
        check("t2_fin", fin, 1);
        repeat (3) @(negedge clk);
        check("t2_status", {fin, err, busy}, 3'b100);
        check("t2_starts", flv_starts, 0);
        check("t2_nwr", wr_addr_q.size(), 0);

        // no leaves: error
        do_reset();
        pulse_start(9'd0);
        check("t3_err", {fin, err, busy}, 3'b010);
        // start is ignored once out of IDLE
        pulse_start(9'd3);
        check("t3_stuck", {err, busy, flv_starts[0]}, 3'b100);

        // delayed WIPE2 ack and a freeze in the middle of WRSUM
        do_reset();
        v_l1[0] = 9'h010; v_l2[0] = 9'h020; v_sum[0] = 64'h30;
        ack_dly[1] = 5;
        ack_dly[2] = 6;
        pulse_start(9'd2);
        wait_req_at("t4_wrsum", 9'd256, 100);
        en_state = 4'd3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("t4_frz_req%0d", i), {sram_req, sram_addr}, {1'b1, 9'd256});
            check($sformatf("t4_frz_wd%0d", i), sram_wdata, 64'h30);
            check($sformatf("t4_frz_misc%0d", i), {flv_start, node_valid, sum_cnt}, 0);
        end
        en_state = 4'd2;
        wait_end("t4", 200);
        ea = '{9'h010, 9'h020, 9'd256, 9'd0, 9'd0, 9'd0};
        ed = '{64'd0, 64'd0, 64'h30, 64'd0, 64'd0, 64'd0};
        check_writes("t4", ea, ed, 3);
        check("t4_fin", {fin, err}, 2'b10);
        check("t4_sumcnt", sum_cnt, 1);
        check("t4_starts", flv_starts, 1);
        if (nd_id_q.size() == 1)
            check("t4_n0", {nd_id_q[0], nd_l_q[0], nd_r_q[0]}, {7'd0, 9'h010, 9'h020});
        else
            check("t4_nnodes", nd_id_q.size(), 1);

        // bad FLV results: duplicate ids, then invalid sentinel
        do_reset();
        v_l1[0] = 9'h041; v_l2[0] = 9'h041; v_sum[0] = 64'd7;
        pulse_start(9'd3);
        wait_end("t5a", 50);
        check("t5a_err", {fin, err, sram_req}, 3'b010);
        check("t5a_nwr", wr_addr_q.size(), 0);
        do_reset();
        v_l1[0] = 9'h041; v_l2[0] = 9'h180; v_sum[0] = 64'd7;
        pulse_start(9'd3);
        wait_end("t5b", 50);
        check("t5b_err", {fin, err, sram_req}, 3'b010);
        check("t5b_nwr", wr_addr_q.size(), 0);

        // node record held for 10 cycles before acceptance
        do_reset();
        v_l1[0] = 9'h005; v_l2[0] = 9'h006; v_sum[0] = 64'd11;
        rdy_dly[0] = 10;
        pulse_start(9'd2);
        for (int i = 0; i < 50 && !node_valid; i++) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("t6_hold%0d", i), {node_valid, node_id, node_l, node_r},
                  {1'b1, 7'd0, 9'h005, 9'h006});
            check($sformatf("t6_cnt%0d", i), sum_cnt, 0);
            @(negedge clk);
        end
        wait_end("t6", 50);
        check("t6_sumcnt", sum_cnt, 1);
        check("t6_nnodes", nd_id_q.size(), 1);
        check("t6_fin", fin, 1);

        // reset in the middle of WIPE1
        do_reset();
        v_l1[0] = 9'h041; v_l2[0] = 9'h042; v_sum[0] = 64'd5;
        ack_dly[0] = 3;
        pulse_start(9'd3);
        wait_req_at("t7_wipe1", 9'h041, 50);
        nRst = 1'b0;
        #1;
        check_outputs_zero("t7_midrst");
        @(negedge clk);
        clear_model();
        nRst = 1'b1;
        pulse_start(9'd1);
        check("t7_idle_fin", {fin, err}, 2'b10);

`ifdef T05_FLV_CTRL_TIMEOUT_EN
        // FLV never answers: watchdog fires TIMEOUT_CYC cycles after launch
        do_reset();
        flv_mute = 1'b1;
        pulse_start(9'd2);
        for (int i = 0; i < 20 && !flv_start; i++) @(negedge clk);
        check("t8_launch", flv_start, 1);
        begin
            int k;
            k = 0;
            while (!err && k < TIMEOUT_CYC + 50) begin
                @(negedge clk);
                k++;
            end
            check("t8_err", err, 1);
            check("t8_latency", k, TIMEOUT_CYC);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: observed hang expected completion");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/t05_flv_controller.md
Name: t05_flv_controller

Overview:
- Sequences Huffman tree construction around the find-least-value (FLV) datapath.
- Repeatedly launches an FLV pass and collects the two least nodes and their sum.
- Zeroes (wipes) the two consumed entries in SRAM, writes the merged sum node to SRAM, and emits a tree-node record.
- Finishes when one root remains. Sits between the top-level state controller (en_state) and the shared SRAM port.

Parameters:
- DATA_W, 64, histogram/sum value width
- NODE_W, 9, node id width; bit 8 = sum node, bits 7:0 = char or sum index
- SUM_BASE, 256, SRAM address of sum node 0
- MAX_SUMS, 128, sum-node capacity (addresses 256..383)
- TIMEOUT_CYC, 1024, watchdog limit (optional feature only)

Ports:
- clk  in  1  system clock
- nRst  in  1  asynchronous active-low reset
- en_state  in  4  top state; block advances only when en_state==2
- start  in  1  pulse; begin tree build
- leaf_cnt  in  9  number of nonzero histogram entries (0..256)
- flv_start  out  1  one-cycle pulse launching an FLV pass
- flv_done  in  1  FLV pass result valid
- flv_least1  in  9  smallest node id
- flv_least2  in  9  second-smallest node id
- flv_sum  in  64  sum of the two values
- sram_req  out  1  SRAM request
- sram_wr  out  1  1=write (always 1 from this block)
- sram_addr  out  9  SRAM word address
- sram_wdata  out  64  write data
- sram_ack  in  1  request accepted this cycle
- node_valid  out  1  tree-node record valid
- node_ready  in  1  consumer accepts record
- node_id  out  7  index of the new sum node
- node_l  out  9  left child (least1)
- node_r  out  9  right child (least2)
- sum_cnt  out  8  sum nodes created so far
- busy  out  1  FSM not in IDLE/DONE/ERR
- fin  out  1  tree complete (level)
- err  out  1  error (level)

Behaviour:
- Reset: all outputs 0; FSM=IDLE; remaining=0; sum_cnt=0.
- Freeze: en_state!=2 freezes all registers; sram_req/node_valid and their address/data stay stable; flv_start is forced 0.
- Node-to-address map: id[8]=0 -> addr id[7:0]; id[8]=1 -> addr SUM_BASE+id[7:0].
- IDLE: on start, register remaining=leaf_cnt.
  - leaf_cnt==0 -> ERR.
  - leaf_cnt==1 -> DONE (sum_cnt=0).
  - otherwise -> LAUNCH.
  - start while not IDLE is ignored.
- LAUNCH: flv_start=1 for exactly one cycle -> WAIT_FLV.
- WAIT_FLV: on flv_done, latch least1/least2/sum.
  - least1==least2, or either has id[8:7]==2'b11 (invalid sentinel) -> ERR.
  - else -> WIPE1.
- WIPE1: sram_req=1, addr=map(least1), wdata=0; hold until sram_ack -> WIPE2.
- WIPE2: same for least2 -> WRSUM.
- WRSUM: addr=SUM_BASE+sum_cnt, wdata=latched sum; on ack -> EMIT.
- EMIT: node_valid=1, node_id=sum_cnt[6:0], node_l=least1, node_r=least2.
  - On node_ready: sum_cnt+=1, remaining-=1.
  - If remaining (pre-decrement) ==2 -> DONE; else -> LAUNCH.
- Latency: one SRAM transaction per ack cycle. Minimum pass = 1 (launch) + FLV time + 3 acks + 1 emit.
- Capacity: sum_cnt==MAX_SUMS entering WRSUM -> ERR (cannot occur for leaf_cnt<=129; checked defensively).
- DONE: fin=1 until reset.
- ERR: err=1 until reset; sram_req=0, node_valid=0.
- Width: remaining is 9 bits and never underflows. sum_cnt wraps are impossible because of the capacity check.
- Reset mid-operation: immediate return to IDLE; any outstanding SRAM request is dropped.

Optional Feature:
- Macro: T05_FLV_CTRL_TIMEOUT_EN.
- With: a 10-bit watchdog clears on every state change and counts while in WAIT_FLV, WIPE1, WIPE2 or WRSUM with en_state==2. Reaching TIMEOUT_CYC -> ERR.
- Without: no counter; the block waits indefinitely.

Decomposition:
- Package t05_flv_pkg holds:
  - FSM enum flv_ctrl_state_t (IDLE, LAUNCH, WAIT_FLV, WIPE1, WIPE2, WRSUM, EMIT, DONE, ERR)
  - constants SUM_BASE, MAX_SUMS, STATE_FLV=4'd2, NODE_INVALID=9'b110000000
  - function node2addr
- One natural sub-module: t05_flv_sram_seq, a request/ack holder that keeps address/data stable until ack. Everything else stays flat.

Test Plan:
- leaf_cnt=3, pulse start; FLV returns (0x041,0x042,sum 5), then (0x100,0x043,sum 9) -> writes in order: addr 0x41=0, 0x42=0, 256=5, 256=0, 0x43=0, 257=9; nodes (0,0x041,0x042), (1,0x100,0x043); fin=1, sum_cnt=2.
- leaf_cnt=1 -> fin=1 one cycle after start; no flv_start, no SRAM request. leaf_cnt=0 -> err=1.
- sram_ack delayed 5 cycles in WIPE2, and en_state=3 for 4 cycles mid-WRSUM -> sram_addr/wdata stable throughout; no extra flv_start; sequence completes correctly.
- flv_least1=flv_least2=0x041, or flv_least2=0x180 -> err=1, and no SRAM write is issued.
- node_ready held low 10 cycles in EMIT -> node_valid and fields stable; sum_cnt increments only on the accept cycle. Also: nRst asserted mid-WIPE1 -> all outputs 0, FSM back in IDLE.
- T05_FLV_CTRL_TIMEOUT_EN defined, flv_done never asserted -> err=1 exactly TIMEOUT_CYC cycles after flv_start.
